// File: rtl/motor_drive_ctrl.sv
// motor_drive_ctrl: NUM_CH H-bridge driver with period-aligned PWM duty, reversal dead-time and latched overcurrent fault.
module motor_drive_ctrl #(
    parameter int CNT_W    = 15,
    parameter int NUM_CH   = 2,
    parameter int DUTY1    = 23550,
    parameter int DUTY2    = 26555,
    parameter int DUTY3    = 32768,
    parameter int DEADTIME = 1000,
    parameter int OC_FILT  = 64,
    parameter int OC_HOLD  = 50000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        speed_sel,
    input  logic              dir_rev,
    input  logic              ips_n,
    input  logic [NUM_CH-1:0] oc_in,
    output logic [NUM_CH-1:0] en,
    output logic [NUM_CH-1:0] in1,
    output logic [NUM_CH-1:0] in2,
    output logic              fault,
    output logic [1:0]        speed_code,
    output logic              dir_code
);
    typedef enum logic [1:0] {IDLE, RUN, DEAD, FAULT} state_t;
    localparam int FW = $clog2(OC_FILT + 1);
    localparam int DW = $clog2(DEADTIME + 1);
    localparam int HW = $clog2(OC_HOLD + 1);
    localparam logic [CNT_W:0] D1 = (CNT_W+1)'(DUTY1);
    localparam logic [CNT_W:0] D2 = (CNT_W+1)'(DUTY2);
    localparam logic [CNT_W:0] D3 = (CNT_W+1)'(DUTY3);

    state_t state, nxt;
    logic [2:0] spd_m, spd_s;
    logic dir_m, dir_s, ips_m, ips_s;
    logic [NUM_CH-1:0] oc_m, oc_s;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0] duty, dec_duty;
    logic [1:0] dec_code;
    logic [FW-1:0] filt [NUM_CH];
    logic [DW-1:0] dead_cnt;
    logic [HW-1:0] hold_cnt;
    logic trip, hold_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {spd_m, spd_s, dir_m, dir_s} <= '0;
            {ips_m, ips_s} <= 2'b11;
            {oc_m, oc_s} <= '0;
        end else begin
            {spd_s, spd_m} <= {spd_m, speed_sel};
            {dir_s, dir_m} <= {dir_m, dir_rev};
            {ips_s, ips_m} <= {ips_m, ips_n};
            {oc_s, oc_m} <= {oc_m, oc_in};
        end
    end

    always_comb begin
        dec_code = (spd_s == 3'b001) ? 2'd1 : (spd_s == 3'b010) ? 2'd2 : (spd_s == 3'b100) ? 2'd3 : 2'd0;
        dec_duty = (dec_code == 2'd1) ? D1 : (dec_code == 2'd2) ? D2 : (dec_code == 2'd3) ? D3 : '0;
        trip = 1'b0;
        for (int i = 0; i < NUM_CH; i++) trip = trip | (filt[i] == FW'(OC_FILT));
        hold_done = hold_cnt == HW'(OC_HOLD - 1);
    end

    // Overcurrent takes priority over every transition; re-trips inside FAULT are ignored
    always_comb begin
        nxt = state;
        case (state)
            IDLE:  if (duty != '0) nxt = (dir_s == dir_code) ? RUN : DEAD;
            RUN:   nxt = (duty == '0) ? IDLE : (dir_s != dir_code) ? DEAD : RUN;
            DEAD:  if (dead_cnt == DW'(DEADTIME - 1)) nxt = IDLE;
            FAULT: if (hold_done && spd_s == 3'b000) nxt = IDLE;
        endcase
        if (trip && state != FAULT) nxt = FAULT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            duty <= '0;
            speed_code <= 2'd0;
            dir_code <= 1'b0;
            dead_cnt <= '0;
            hold_cnt <= '0;
            en <= '0;
            for (int i = 0; i < NUM_CH; i++) filt[i] <= '0;
        end else begin
            state <= nxt;
            cnt <= cnt + 1'b1;
            // Duty only changes at the period boundary so no partial pulses appear
            if (&cnt) begin
                duty <= dec_duty;
                speed_code <= dec_code;
            end
            if (state == DEAD && nxt == IDLE) dir_code <= dir_s;
            dead_cnt <= (state == DEAD) ? dead_cnt + 1'b1 : '0;
            hold_cnt <= (state != FAULT) ? '0 : hold_done ? hold_cnt : hold_cnt + 1'b1;
            en <= {NUM_CH{({1'b0, cnt} < duty) && state == RUN && !ips_s}};
            for (int i = 0; i < NUM_CH; i++)
                filt[i] <= !oc_s[i] ? '0 : (filt[i] == FW'(OC_FILT)) ? filt[i] : filt[i] + 1'b1;
        end
    end

    assign fault = state == FAULT;
    assign in1 = {NUM_CH{dir_code}};
    assign in2 = ~in1;
endmodule
